// File: rtl/pkt_buffer_writer_if.sv
// Shared types and the bundled port interface of the packet-buffer writer:
// RX flit stream in, emptylist pop, packet-buffer write port, metadata out.
package pkt_buffer_pkg;
    localparam int PKT_AWIDTH    = 9;
    localparam int FLIT_IDX_W    = 5;
    localparam int PKTBUF_AWIDTH = PKT_AWIDTH + FLIT_IDX_W;
    localparam int LEN_W         = 16;

    localparam logic [2:0] PKT_PCIE = 3'b001;
    localparam logic [2:0] PKT_ETH  = 3'b010;
    localparam logic [2:0] PKT_DROP = 3'b100;

    typedef struct packed {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        logic [5:0]   empty;
    } flit_t;

    typedef struct packed {
        logic [PKT_AWIDTH-1:0] pkt_id;
        logic [5:0]            flits;
        logic [LEN_W-1:0]      len;
        logic [2:0]            pkt_flags;
        logic [7:0]            port;
        logic [31:0]           hash;
    } metadata_t;
endpackage

interface pkt_buffer_writer_if;
    import pkt_buffer_pkg::*;

    logic                     in_sop;
    logic                     in_eop;
    logic                     in_valid;
    logic [511:0]             in_data;
    logic [5:0]               in_empty;
    logic [2:0]               in_pkt_flags;
    logic                     in_ready;
    logic [PKT_AWIDTH-1:0]    emptylist_out_data;
    logic                     emptylist_out_valid;
    logic                     emptylist_out_ready;
    logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address;
    logic                     pkt_buffer_write;
    flit_t                    pkt_buffer_writedata;
    logic                     meta_valid;
    metadata_t                meta_data;
    logic                     meta_ready;

    // Writer's view: it masters the packet-buffer port and the metadata record
    modport master (
        input  in_sop, in_eop, in_valid, in_data, in_empty, in_pkt_flags,
        output in_ready,
        input  emptylist_out_data, emptylist_out_valid,
        output emptylist_out_ready,
        output pkt_buffer_address, pkt_buffer_write, pkt_buffer_writedata,
        output meta_valid, meta_data,
        input  meta_ready
    );

    // Surrounding logic: RX source, emptylist, packet buffer, data mover
    modport slave (
        output in_sop, in_eop, in_valid, in_data, in_empty, in_pkt_flags,
        input  in_ready,
        output emptylist_out_data, emptylist_out_valid,
        input  emptylist_out_ready,
        input  pkt_buffer_address, pkt_buffer_write, pkt_buffer_writedata,
        input  meta_valid, meta_data,
        output meta_ready
    );
endinterface

// File: rtl/pkt_buffer_writer.sv
// Ingress packet-buffer writer: pops a free packet ID, stores each flit at
// (pktID << 5) + flit index and emits one metadata record per packet.
module pkt_buffer_writer
    import pkt_buffer_pkg::*;
#(
    parameter int MAX_FLITS = 32,
    parameter int LEN_WIDTH = LEN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    pkt_buffer_writer_if.master  bus
);
    // Flit counter wide enough that count*64 overflows LEN_WIDTH before it wraps
    localparam int CNT_W  = LEN_WIDTH - 6 + 1;
    localparam int BYTE_W = CNT_W + 6;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                state;
    logic                  id_held;
    logic [PKT_AWIDTH-1:0] pkt_id;
    logic [CNT_W-1:0]      flit_cnt;
    logic                  truncated;
    logic [2:0]            pkt_flags_q;

    logic                  accept;
    logic                  in_pkt;
    logic                  do_write;
    logic                  close_pkt;
    logic                  trunc_now;
    logic [2:0]            flags_eff;
    logic [CNT_W-1:0]      cur_idx;
    logic [CNT_W-1:0]      next_cnt;
    logic [BYTE_W-1:0]     byte_cnt;
    logic [LEN_WIDTH-1:0]  len_sat;
    logic [5:0]            flits_min;
    metadata_t             meta_next;

    // A stalled full meta register blocks input; no ID means nothing to write into
    assign bus.emptylist_out_ready = !id_held && !rst;
    assign bus.in_ready = id_held && !(bus.meta_valid && !bus.meta_ready) && !rst;

    // Per-flit decode: index, write decision, truncation and the record to load
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        meta_next = '0;
        accept    = bus.in_valid && bus.in_ready;
        in_pkt    = (state == WRITE) || bus.in_sop;
        cur_idx   = (state == WRITE) ? flit_cnt : '0;
        next_cnt  = (&cur_idx) ? cur_idx : cur_idx + 1'b1;
        do_write  = accept && in_pkt && (cur_idx < CNT_W'(MAX_FLITS));
        close_pkt = accept && in_pkt && bus.in_eop;
        trunc_now = ((state == WRITE) && truncated) || (cur_idx >= CNT_W'(MAX_FLITS));
        flags_eff = (state == WRITE) ? pkt_flags_q : bus.in_pkt_flags;
        byte_cnt  = {next_cnt, 6'b0} - BYTE_W'(bus.in_empty);
        len_sat   = (byte_cnt > BYTE_W'({LEN_WIDTH{1'b1}})) ? '1 : byte_cnt[LEN_WIDTH-1:0];
        flits_min = (next_cnt > CNT_W'(MAX_FLITS)) ? 6'(MAX_FLITS) : 6'(next_cnt);

        meta_next.pkt_id    = pkt_id;
        meta_next.flits     = flits_min;
        meta_next.len       = LEN_W'(len_sat);
        meta_next.pkt_flags = trunc_now ? PKT_DROP : flags_eff;
    end

    // Packet FSM: ID ownership, flit counting, write strobe and meta handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= IDLE;
            id_held                <= 1'b0;
            pkt_id                 <= '0;
            flit_cnt               <= '0;
            truncated              <= 1'b0;
            pkt_flags_q            <= '0;
            bus.pkt_buffer_write   <= 1'b0;
            bus.pkt_buffer_address <= '0;
            bus.meta_valid         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; later ones in this block
            // deliberately override earlier ones (new record beats retirement).
            bus.pkt_buffer_write <= do_write;
            if (do_write) begin
                bus.pkt_buffer_address <= {pkt_id, cur_idx[FLIT_IDX_W-1:0]};
            end

            if (bus.meta_ready) begin
                bus.meta_valid <= 1'b0;
            end

            if (bus.emptylist_out_valid && bus.emptylist_out_ready) begin
                id_held <= 1'b1;
                pkt_id  <= bus.emptylist_out_data;
            end

            if (accept && in_pkt) begin
                if (bus.in_eop) begin
                    state          <= IDLE;
                    id_held        <= 1'b0;
                    bus.meta_valid <= 1'b1;
                    flit_cnt       <= '0;
                    truncated      <= 1'b0;
                end else begin
                    state       <= WRITE;
                    flit_cnt    <= next_cnt;
                    truncated   <= trunc_now;
                    pkt_flags_q <= flags_eff;
                end
            end
        end
    end

    // Payload and record capture, qualified by the strobes above
    always_ff @(posedge clk) begin
        // NOTE: wide payload/record registers are not reset; only their valid
        // strobes are, so stale contents are never observed as valid.
        if (do_write) begin
            bus.pkt_buffer_writedata <= {bus.in_data, bus.in_sop, bus.in_eop, bus.in_empty};
        end
        if (close_pkt) begin
            bus.meta_data <= meta_next;
        end
    end
endmodule
